// File: rtl/delta_decoder_if.sv
// Spike-word handshake between an event source and the delta decoder.
// The source offers a 2-bit spike code with valid; the decoder answers with ready.
interface delta_decoder_if;
  logic       spike_valid;
  logic [1:0] spike;
  logic       spike_ready;

  modport master (output spike_valid, output spike, input spike_ready);
  modport slave  (input spike_valid, input spike, output spike_ready);
endinterface

// File: rtl/delta_decoder.sv
// Delta-modulation decoder: buffers up/down spike events in a 4-entry FIFO and
// integrates them into a saturating 5-bit reconstruction with event counters.
module delta_decoder (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4:0]            threshold,
  input  logic                  load,
  input  logic [4:0]            load_value,
  delta_decoder_if.slave        s,
  output logic [4:0]            recon,
  output logic                  recon_valid,
  output logic                  sat_hi,
  output logic                  sat_lo,
  output logic                  err_illegal,
  output logic [7:0]            up_count,
  output logic [7:0]            down_count
);

  logic [3:0] fifo_dir;   // 0 = up, 1 = down
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;

  logic full, empty, accept, push, pop, illegal, pop_dir;
  logic [5:0]        sum;
  logic signed [5:0] diff;
  logic [4:0]        recon_next;
  logic              hi_next, lo_next;

  assign full  = (count == 3'd4);
  assign empty = (count == 3'd0);

  // Ready looks only at registered occupancy, so a full FIFO refuses a word
  // even when the same cycle pops an entry.
  assign s.spike_ready = !full;

  assign accept  = s.spike_valid & !full;
  assign push    = accept & s.spike[0] & !load;            // 01 and 11
  assign illegal = accept & (s.spike == 2'b10) & !load;
  assign pop     = en & !empty & !load;
  assign pop_dir = fifo_dir[rd_ptr];

  assign sum  = {1'b0, recon} + {1'b0, threshold};
  assign diff = $signed({1'b0, recon}) - $signed({1'b0, threshold});

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    recon_next = recon;
    hi_next    = 1'b0;
    lo_next    = 1'b0;
    if (!pop_dir) begin
      if (sum[5]) begin
        recon_next = 5'd31;
        hi_next    = 1'b1;
      end else begin
        recon_next = sum[4:0];
      end
    end else begin
      if (diff[5]) begin
        recon_next = 5'd0;
        lo_next    = 1'b1;
      end else begin
        recon_next = diff[4:0];
      end
    end
  end

  // NOTE: storage cells are not reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!rst && push) fifo_dir[wr_ptr] <= s.spike[1];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      recon       <= '0;
      recon_valid <= 1'b0;
      sat_hi      <= 1'b0;
      sat_lo      <= 1'b0;
      err_illegal <= 1'b0;
      up_count    <= '0;
      down_count  <= '0;
    end else if (load) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      recon       <= load_value;
      recon_valid <= 1'b0;
      sat_hi      <= 1'b0;
      sat_lo      <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase

      if (illegal) err_illegal <= 1'b1;

      recon_valid <= pop;
      sat_hi      <= pop & hi_next;
      sat_lo      <= pop & lo_next;
      if (pop) begin
        recon <= recon_next;
        if (!pop_dir && up_count != 8'hFF)  up_count   <= up_count + 8'd1;
        if (pop_dir && down_count != 8'hFF) down_count <= down_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_delta_decoder.sv
// Directed bench for delta_decoder: hand-computed expectations for reconstruction,
// saturation, FIFO flow control, illegal codes, counter saturation and reset priority.
module tb_delta_decoder;
  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [4:0] threshold, load_value;
  logic [4:0] recon;
  logic       recon_valid, sat_hi, sat_lo, err_illegal;
  logic [7:0] up_count, down_count;

  int n_cmp = 0;
  int n_bad = 0;

  delta_decoder_if bus ();

  delta_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .threshold  (threshold),
    .load       (load),
    .load_value (load_value),
    .s          (bus.slave),
    .recon      (recon),
    .recon_valid(recon_valid),
    .sat_hi     (sat_hi),
    .sat_lo     (sat_lo),
    .err_illegal(err_illegal),
    .up_count   (up_count),
    .down_count (down_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4:0] v);
    load = 1'b1; load_value = v;
    step();
    load = 1'b0;
  endtask

  task automatic push(input logic [1:0] code);
    bus.spike_valid = 1'b1; bus.spike = code;
    step();
    bus.spike_valid = 1'b0; bus.spike = 2'b00;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; threshold = '0; load_value = '0;
    bus.spike_valid = 1'b0; bus.spike = 2'b00;
    step();
    rst = 1'b0;
    check("rst_recon", recon, 0);
    check("rst_valid", recon_valid, 0);
    check("rst_err", err_illegal, 0);
    check("rst_up", up_count, 0);
    check("rst_down", down_count, 0);
    check("rst_ready", bus.spike_ready, 1);

    // Basic up step: 10 + 3 = 13, one cycle after the pop
    do_load(5'd10);
    check("load10", recon, 10);
    threshold = 5'd3;
    push(2'b01);
    en = 1'b1;
    check("pop_cycle_valid", recon_valid, 0);
    step();
    check("up_recon", recon, 13);
    check("up_valid", recon_valid, 1);
    check("up_count1", up_count, 1);
    step();
    check("valid_pulse", recon_valid, 0);

    // Saturation high: 30 + 4 -> 31
    do_load(5'd30);
    threshold = 5'd4;
    push(2'b01);
    step();
    check("sat_recon", recon, 31);
    check("sat_hi", sat_hi, 1);
    check("sat_hi_valid", recon_valid, 1);
    step();
    check("sat_hi_pulse", sat_hi, 0);

    // Saturation low: 2 - 4 -> 0
    do_load(5'd2);
    push(2'b11);
    step();
    check("satlo_recon", recon, 0);
    check("sat_lo", sat_lo, 1);
    check("down_count1", down_count, 1);
    step();
    check("sat_lo_pulse", sat_lo, 0);

    // Fill with en=0: four accepted, fifth refused
    en = 1'b0; threshold = 5'd1;
    do_load(5'd0);
    for (int i = 0; i < 5; i++) begin
      bus.spike_valid = 1'b1; bus.spike = 2'b01;
      check($sformatf("fill_ready%0d", i), bus.spike_ready, (i < 4) ? 1 : 0);
      step();
    end
    bus.spike_valid = 1'b0;
    check("full_ready", bus.spike_ready, 0);
    check("frozen_recon", recon, 0);
    en = 1'b1;
    step();
    check("drain_ready", bus.spike_ready, 1);
    check("drain_recon1", recon, 1);
    for (int i = 2; i <= 4; i++) begin
      step();
      check($sformatf("drain_recon%0d", i), recon, i);
      check($sformatf("drain_valid%0d", i), recon_valid, 1);
    end
    step();
    check("drained_valid", recon_valid, 0);
    check("drained_recon", recon, 4);
    check("up_count6", up_count, 6);

    // Illegal and no-event codes do not occupy the FIFO
    en = 1'b0;
    push(2'b01);
    push(2'b10);
    check("err_set", err_illegal, 1);
    push(2'b00);
    check("err_sticky", err_illegal, 1);
    en = 1'b1;
    step();
    check("one_entry_pop", recon_valid, 1);
    check("one_entry_recon", recon, 5);
    step();
    check("no_second_pop", recon_valid, 0);
    do_load(5'd5);
    check("load_clears_err", err_illegal, 0);
    check("load_keeps_up", up_count, 7);

    // Counter saturation at threshold 0
    rst = 1'b1; step(); rst = 1'b0;
    check("rst2_down", down_count, 0);
    do_load(5'd9);
    threshold = 5'd0;
    bus.spike_valid = 1'b1; bus.spike = 2'b01;
    for (int i = 0; i < 256; i++) step();
    bus.spike_valid = 1'b0;
    step();
    check("thr0_valid", recon_valid, 1);
    step();
    check("up_sat", up_count, 255);
    check("thr0_recon", recon, 9);

    // Reset beats load with FIFO partly full and error set
    en = 1'b0;
    push(2'b10);
    push(2'b01); push(2'b01); push(2'b01);
    rst = 1'b1; load = 1'b1; load_value = 5'd17;
    step();
    rst = 1'b0; load = 1'b0;
    check("rstld_recon", recon, 0);
    check("rstld_up", up_count, 0);
    check("rstld_err", err_illegal, 0);
    check("rstld_ready", bus.spike_ready, 1);
    en = 1'b1;
    step();
    check("rstld_empty", recon_valid, 0);
    check("rstld_recon2", recon, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/delta_decoder.md
DELTA_DECODER -- requirements
Module: delta_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port en, input, 1 bit: decode enable; when low, the FIFO holds and recon is frozen.
REQ-004 SHALL have port spike_valid, input, 1 bit: spike word offered this cycle.
REQ-005 SHALL have port spike, input, 2 bits: encoded spike.
  - 2'b00 = no event
  - 2'b01 = on (up)
  - 2'b11 = off (down)
  - 2'b10 = illegal
REQ-006 SHALL have port spike_ready, output, 1 bit: FIFO can accept a spike word.
REQ-007 SHALL have port threshold, input, 5 bits: unsigned step size applied per event.
REQ-008 SHALL have port load, input, 1 bit: force reconstruction to load_value.
REQ-009 SHALL have port load_value, input, 5 bits: value used on load.
REQ-010 SHALL have port recon, output, 5 bits: reconstructed sample, unsigned.
REQ-011 SHALL have port recon_valid, output, 1 bit: one-cycle pulse; recon updated by an event.
REQ-012 SHALL have port sat_hi, output, 1 bit: one-cycle pulse with recon_valid; up step clamped at 31.
REQ-013 SHALL have port sat_lo, output, 1 bit: one-cycle pulse with recon_valid; down step clamped at 0.
REQ-014 SHALL have port err_illegal, output, 1 bit: sticky; illegal spike word accepted.
REQ-015 SHALL have port up_count, output, 8 bits: saturating count of decoded up events.
REQ-016 SHALL have port down_count, output, 8 bits: saturating count of decoded down events.

Function
REQ-017 SHALL contain a 4-entry FIFO of 1-bit event direction (0=up, 1=down) with 3-bit occupancy.
REQ-018 SHALL drive spike_ready = !full, combinationally from registered occupancy only.
REQ-019 SHALL accept a word on the cycle when spike_valid & spike_ready are both high.
REQ-020 SHALL handle accepted words by code:
  - 01 or 11: push one entry.
  - 00: discard; no state change.
  - 10: discard and set err_illegal.
REQ-021 SHALL, when full, not accept a word even if a pop occurs in the same cycle (ready is not pop-aware).
REQ-022 SHALL pop one entry per cycle when en=1 and the FIFO is not empty.
REQ-023 SHALL allow a push and a pop in the same cycle when not full; occupancy is then unchanged.
REQ-024 SHALL compute an up pop as recon_next = min(recon + threshold, 31), using a 6-bit sum; sat_hi=1 iff the sum exceeds 31.
REQ-025 SHALL compute a down pop as recon_next = max(recon - threshold, 0), using a 6-bit signed difference; sat_lo=1 iff the difference is below 0.
REQ-026 SHALL register recon, recon_valid, sat_hi and sat_lo on the pop edge, giving one cycle latency from pop to output.
REQ-027 SHALL sample threshold on the pop cycle; with threshold=0 recon is unchanged, recon_valid still pulses and the counters still increment.
REQ-028 SHALL increment up_count or down_count per popped event, holding at 255 with no wrap.
REQ-029 SHALL give load priority over every other action when load=1:
  - recon <= load_value
  - FIFO flushed (occupancy 0)
  - err_illegal cleared
  - recon_valid, sat_hi and sat_lo = 0 next cycle
  - counters unchanged
  - any concurrent input word is dropped and spike_ready stays as computed
REQ-030 SHALL, with en=0, still accept pushes until full.

Reset
REQ-031 SHALL reset synchronously, when rst=1 at a clock edge, to:
  - recon=0
  - recon_valid=0, sat_hi=0, sat_lo=0
  - err_illegal=0
  - up_count=0, down_count=0
  - FIFO empty, so spike_ready=1 next cycle
REQ-032 SHALL give rst priority over load and all pushes and pops, and SHALL discard FIFO contents on mid-operation reset.

Verification
REQ-033 SHALL cover: rst, load 10, threshold=3, push 01, en=1 -> pop next cycle; recon=13 with recon_valid the cycle after; up_count=1.
REQ-034 SHALL cover: recon=30, threshold=4, push 01 -> recon=31, sat_hi=1 for one cycle; recon=2, push 11 -> recon=0, sat_lo=1.
REQ-035 SHALL cover: en=0, push five 01 words back-to-back -> first four accepted, spike_ready=0 on the fifth; en=1 -> four pops on consecutive cycles, spike_ready=1 after the first pop.
REQ-036 SHALL cover: push 10 -> err_illegal=1 and occupancy unchanged; push 00 -> no change; load -> err_illegal=0.
REQ-037 SHALL cover: 256 up events at threshold=0 -> up_count=255, recon unchanged.
REQ-038 SHALL cover: FIFO holding 3 entries, then rst=1 and load=1 in the same cycle -> all reset values, recon=0 (not load_value).
